// File: rtl/updown_count_ctrl_pkg.sv
// Shared types and constants for the up/down counter sequencer.
// Imported by the controller and by its step-counter sub-module.
package updown_count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/updown_count_ctrl_step_counter.sv
// Loadable WIDTH-bit up/down counter with step enable.
// Also flags, one cycle early, that the next step will wrap.
module updn_step_counter
  import updown_count_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step_en,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             wrap_next
);

  // Load wins over stepping so an accept never counts as a step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (step_en) begin
      if (dir == DIR_DOWN) q <= q - WIDTH'(1);
      else                 q <= q + WIDTH'(1);
    end
  end

  assign qb = ~q;

  always_comb begin
    wrap_next = 1'b0;
    if (step_en && !load) begin
      if (dir == DIR_DOWN) wrap_next = (q == '0);
      else                 wrap_next = (q == '1);
    end
  end

endmodule

// File: rtl/updown_count_ctrl.sv
// Command-driven sequencer: accepts {dir, start, len} and runs a bounded
// count, reporting completion and wrap-around as one-cycle pulses.
module updown_count_ctrl
  import updown_count_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_len,
  input  logic             hold,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_t           state, state_next;
  logic [WIDTH-1:0] remaining;
  logic             dir_r;
  logic             accept;
  logic             step_en;
  logic             wrap_next;

  assign accept  = (state == IDLE) && cmd_valid;
  assign step_en = (state == RUN) && !hold;

  updn_step_counter #(.WIDTH(WIDTH)) u_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_val  (cmd_start),
    .step_en   (step_en),
    .dir       (dir_r),
    .q         (q),
    .qb        (qb),
    .wrap_next (wrap_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      dir_r     <= DIR_UP;
      wrap      <= 1'b0;
    end else begin
      state <= state_next;
      wrap  <= wrap_next;
      if (accept) begin
        remaining <= cmd_len;
        dir_r     <= cmd_dir;
      end else if (step_en) begin
        remaining <= remaining - WIDTH'(1);
      end
    end
  end

  // A zero-length command skips RUN and reports completion directly.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (cmd_valid) state_next = (cmd_len != '0) ? RUN : DONE;
      RUN:  if (!hold && remaining == WIDTH'(1)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Directed scoreboard bench for updown_count_ctrl: a behavioural model
// pushes the expected outputs of each cycle, which are popped after the edge.
module tb_updown_count_ctrl;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] qb;
    logic       ready;
    logic       busy;
    logic       done;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [3:0] cmd_start;
  logic [3:0] cmd_len;
  logic       hold;
  logic [3:0] q;
  logic [3:0] qb;
  logic       busy;
  logic       done;
  logic       wrap;

  int checks   = 0;
  int failures = 0;
  int wrapSeen = 0;

  exp_t sb[$];

  int         mstate;
  logic [3:0] mq;
  logic [3:0] mrem;
  logic       mdir;
  logic       mwrap;

  updown_count_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_start (cmd_start),
    .cmd_len   (cmd_len),
    .hold      (hold),
    .q         (q),
    .qb        (qb),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops the expectation for the cycle just clocked and compares every output.
  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s scoreboard empty observed=%0d expected=1", tag, sb.size());
      return;
    end
    e = sb.pop_front();
    check1({tag, ".q"},     q,         e.q);
    check1({tag, ".qb"},    qb,        e.qb);
    check1({tag, ".ready"}, {3'b0, cmd_ready}, {3'b0, e.ready});
    check1({tag, ".busy"},  {3'b0, busy},      {3'b0, e.busy});
    check1({tag, ".done"},  {3'b0, done},      {3'b0, e.done});
    check1({tag, ".wrap"},  {3'b0, wrap},      {3'b0, e.wrap});
    if (wrap === 1'b1) wrapSeen++;
  endtask

  // Drives one cycle of inputs, advances the model, and clocks the DUT.
  task automatic applyStimulus(input string tag, input logic valid, input logic dir,
                               input logic [3:0] start, input logic [3:0] len,
                               input logic hld);
    exp_t e;
    cmd_valid = valid;
    cmd_dir   = dir;
    cmd_start = start;
    cmd_len   = len;
    hold      = hld;
    mwrap = 1'b0;
    case (mstate)
      0: if (valid) begin
        mq = start;
        mdir = dir;
        mrem = len;
        mstate = (len != 4'd0) ? 1 : 2;
      end
      1: if (!hld) begin
        if (mdir == 1'b0) begin
          mwrap = (mq == 4'hF);
          mq = mq + 4'd1;
        end else begin
          mwrap = (mq == 4'h0);
          mq = mq - 4'd1;
        end
        mrem = mrem - 4'd1;
        if (mrem == 4'd0) mstate = 2;
      end
      default: mstate = 0;
    endcase
    e.q     = mq;
    e.qb    = ~mq;
    e.ready = (mstate == 0);
    e.busy  = (mstate == 1);
    e.done  = (mstate == 2);
    e.wrap  = mwrap;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
  endtask

  // Raises reset between edges and checks outputs before any edge occurs.
  task automatic asyncReset(input string tag);
    #2;
    rst = 1'b1;
    cmd_valid = 1'b0;
    #1;
    check1({tag, ".q"},     q,  4'h0);
    check1({tag, ".qb"},    qb, 4'hF);
    check1({tag, ".ready"}, {3'b0, cmd_ready}, 4'd1);
    check1({tag, ".busy"},  {3'b0, busy},      4'd0);
    check1({tag, ".done"},  {3'b0, done},      4'd0);
    check1({tag, ".wrap"},  {3'b0, wrap},      4'd0);
    mstate = 0;
    mq = 4'h0;
    mrem = 4'h0;
    mdir = 1'b0;
    mwrap = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir = 1'b0;
    cmd_start = 4'h0;
    cmd_len = 4'h0;
    hold = 1'b0;
    mstate = 0;
    mq = 4'h0;
    mrem = 4'h0;
    mdir = 1'b0;
    mwrap = 1'b0;

    @(posedge clk);
    #1;
    asyncReset("reset");
    idleCycle("idle0");

    // Up run: 3 -> 8
    applyStimulus("up.acc", 1'b1, 1'b0, 4'd3, 4'd5, 1'b0);
    for (int i = 0; i < 5; i++) idleCycle("up.run");
    check1("up.final_q", q, 4'd8);
    idleCycle("up.idle");
    check1("up.hold_q", q, 4'd8);

    // Down wrap: 1,0,F,E
    wrapSeen = 0;
    applyStimulus("dn.acc", 1'b1, 1'b1, 4'd1, 4'd3, 1'b0);
    for (int i = 0; i < 3; i++) idleCycle("dn.run");
    idleCycle("dn.idle");
    check1("dn.final_q", q, 4'hE);
    check1("dn.wrap_count", 4'(wrapSeen), 4'd1);

    // Up wrap: F -> 1
    wrapSeen = 0;
    applyStimulus("upw.acc", 1'b1, 1'b0, 4'hF, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++) idleCycle("upw.run");
    check1("upw.wrap_count", 4'(wrapSeen), 4'd1);

    // Hold: freeze at 2 for two cycles
    applyStimulus("hold.acc", 1'b1, 1'b0, 4'd0, 4'd4, 1'b0);
    applyStimulus("hold.s1", 1'b0, 1'b0, 4'd7, 4'd7, 1'b0);
    applyStimulus("hold.s2", 1'b0, 1'b0, 4'd7, 4'd7, 1'b0);
    applyStimulus("hold.h1", 1'b0, 1'b0, 4'd7, 4'd7, 1'b1);
    check1("hold.frozen1", q, 4'd2);
    applyStimulus("hold.h2", 1'b0, 1'b0, 4'd7, 4'd7, 1'b1);
    check1("hold.frozen2", q, 4'd2);
    applyStimulus("hold.s3", 1'b0, 1'b0, 4'd7, 4'd7, 1'b0);
    applyStimulus("hold.s4", 1'b0, 1'b0, 4'd7, 4'd7, 1'b0);
    applyStimulus("hold.done", 1'b0, 1'b0, 4'd7, 4'd7, 1'b1);
    check1("hold.final_q", q, 4'd4);
    idleCycle("hold.idle");

    // Zero length: valid during DONE must be ignored
    applyStimulus("zero.acc", 1'b1, 1'b0, 4'd9, 4'd0, 1'b0);
    check1("zero.q", q, 4'd9);
    applyStimulus("zero.done", 1'b1, 1'b1, 4'd3, 4'd5, 1'b0);
    idleCycle("zero.idle");
    check1("zero.q_kept", q, 4'd9);

    // Back-to-back accepts with cmd_valid held
    applyStimulus("b2b.acc1", 1'b1, 1'b1, 4'd5, 4'd1, 1'b0);
    applyStimulus("b2b.run1", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    applyStimulus("b2b.done1", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    applyStimulus("b2b.acc2", 1'b1, 1'b0, 4'hA, 4'd0, 1'b0);
    applyStimulus("b2b.done2", 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    idleCycle("b2b.idle");

    // Reset mid-run, then a fresh command
    applyStimulus("rmr.acc", 1'b1, 1'b0, 4'd2, 4'd10, 1'b0);
    for (int i = 0; i < 3; i++) idleCycle("rmr.run");
    asyncReset("rmr.reset");
    idleCycle("rmr.idle");
    applyStimulus("rmr.acc2", 1'b1, 1'b0, 4'd5, 4'd1, 1'b0);
    idleCycle("rmr.run2");
    idleCycle("rmr.done2");
    check1("rmr.final_q", q, 4'd6);
    idleCycle("rmr.idle2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
